// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
//   Direct-mapped, write-back, write-allocate data cache controller placed
//   between the CPU data port (16-bit words) and the D-side of the
//   line-burst memory (4-word / 64-bit lines). A miss on a dirty line
//   first stores the victim line (WRITEBACK), then fetches the requested
//   line (FILL). After the fill, the lookup is replayed and always hits.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   c_read      CPU read request, held until c_ready
//   c_write     CPU write request, held until c_ready (wins over c_read)
//   c_address   CPU word address {tag, index, word[1:0]}
//   c_wdata     CPU write data
//   c_rdata     read data, valid while c_ready=1
//   c_ready     one-cycle completion pulse
//   m_readM     memory burst-read request (FILL)
//   m_writeM    memory burst-write request (WRITEBACK)
//   m_address   memory line address, [1:0] always 00
//   m_data      64-bit line bus, driven only during WRITEBACK
//   hit_count   saturating hit counter
//   miss_count  saturating miss counter
// ---------------------------------------------------------------------------
module dcache_controller #(
  parameter int NUM_LINES    = 4,
  parameter int WORD_SIZE    = 16,
  parameter int FETCH_SIZE   = 64,
  parameter int FILL_CYCLES  = 5,
  parameter int STORE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_read,
  input  logic                  c_write,
  input  logic [WORD_SIZE-1:0]  c_address,
  input  logic [WORD_SIZE-1:0]  c_wdata,
  output logic [WORD_SIZE-1:0]  c_rdata,
  output logic                  c_ready,
  output logic                  m_readM,
  output logic                  m_writeM,
  output logic [WORD_SIZE-1:0]  m_address,
  inout  logic [FETCH_SIZE-1:0] m_data,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 14 - INDEX_W;
  localparam int MAX_CYC = (FILL_CYCLES > STORE_CYCLES) ? FILL_CYCLES : STORE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] STORE_LAST = CNT_W'(STORE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    DONE
  } state_t;

  state_t                 state;
  logic [WORD_SIZE-1:0]   reqAddr;
  logic [WORD_SIZE-1:0]   reqWdata;
  logic                   reqWrite;
  logic                   refill;
  logic [CNT_W-1:0]       cnt;

  logic [TAG_W-1:0]       tagArr  [NUM_LINES];
  logic [FETCH_SIZE-1:0]  lineArr [NUM_LINES];
  logic [NUM_LINES-1:0]   valid;
  logic [NUM_LINES-1:0]   dirty;

  logic [TAG_W-1:0]       reqTag;
  logic [INDEX_W-1:0]     reqIdx;
  logic [1:0]             reqWord;
  logic                   hit;

  assign reqTag  = reqAddr[WORD_SIZE-1 -: TAG_W];
  assign reqIdx  = reqAddr[INDEX_W+1:2];
  assign reqWord = reqAddr[1:0];
  assign hit     = valid[reqIdx] && (tagArr[reqIdx] == reqTag);

  // Memory-side outputs are pure decodes of the state, so the two
  // request strobes can never overlap and are low outside the bursts.
  assign m_readM  = (state == FILL);
  assign m_writeM = (state == WRITEBACK);

  always_comb begin
    m_address = {reqTag, reqIdx, 2'b00};
    if (state == WRITEBACK) begin
      m_address = {tagArr[reqIdx], reqIdx, 2'b00};
    end
  end

  assign m_data = (state == WRITEBACK) ? lineArr[reqIdx] : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      reqAddr    <= '0;
      reqWdata   <= '0;
      reqWrite   <= 1'b0;
      refill     <= 1'b0;
      cnt        <= '0;
      valid      <= '0;
      dirty      <= '0;
      c_ready    <= 1'b0;
      c_rdata    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (c_read || c_write) begin
            reqAddr  <= c_address;
            reqWdata <= c_wdata;
            reqWrite <= c_write;
            refill   <= 1'b0;
            state    <= LOOKUP;
          end
        end

        LOOKUP: begin
          cnt <= '0;
          if (hit) begin
            if (reqWrite) begin
              lineArr[reqIdx][reqWord*WORD_SIZE +: WORD_SIZE] <= reqWdata;
              dirty[reqIdx] <= 1'b1;
            end else begin
              c_rdata <= lineArr[reqIdx][reqWord*WORD_SIZE +: WORD_SIZE];
            end
            c_ready <= 1'b1;
            // The replayed lookup after a refill is part of the miss.
            if (!refill && (hit_count != '1)) begin
              hit_count <= hit_count + 16'd1;
            end
            state <= DONE;
          end else begin
            if (miss_count != '1) begin
              miss_count <= miss_count + 16'd1;
            end
            refill <= 1'b1;
            if (valid[reqIdx] && dirty[reqIdx]) begin
              state <= WRITEBACK;
            end else begin
              state <= FILL;
            end
          end
        end

        WRITEBACK: begin
          if (cnt == STORE_LAST) begin
            cnt   <= '0;
            state <= FILL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        FILL: begin
          if (cnt == FILL_LAST) begin
            cnt             <= '0;
            lineArr[reqIdx] <= m_data;
            tagArr[reqIdx]  <= reqTag;
            valid[reqIdx]   <= 1'b1;
            dirty[reqIdx]   <= 1'b0;
            state           <= LOOKUP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          c_ready <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// ---------------------------------------------------------------------------
// tb_dcache_controller
//   Directed plus randomized bench for dcache_controller. A burst memory
//   model answers FILL/WRITEBACK; a reference model tracks the CPU-visible
//   word image, the line directory and the backing-store image to predict
//   latency, data, bursts and counters for every access.
// ---------------------------------------------------------------------------
module tb_dcache_controller;

  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_read, c_write;
  logic [15:0] c_address, c_wdata, c_rdata;
  logic        c_ready, m_readM, m_writeM;
  logic [15:0] m_address, hit_count, miss_count;
  wire  [63:0] m_data;
  logic [63:0] memLine;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem    [65536];
  logic [15:0] refMem [65536];
  logic [15:0] shadow [65536];
  bit          mValid [NL];
  bit          mDirty [NL];
  int          mTag   [NL];
  int          expHits, expMisses;

  always #5 clk = ~clk;

  dcache_controller #(.NUM_LINES(NL), .FILL_CYCLES(5), .STORE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .c_read(c_read), .c_write(c_write),
    .c_address(c_address), .c_wdata(c_wdata), .c_rdata(c_rdata),
    .c_ready(c_ready), .m_readM(m_readM), .m_writeM(m_writeM),
    .m_address(m_address), .m_data(m_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always_comb memLine = {mem[m_address + 16'd3], mem[m_address + 16'd2],
                         mem[m_address + 16'd1], mem[m_address]};
  assign m_data = m_readM ? memLine : 'z;

  always @(posedge clk) begin
    if (!reset && m_writeM) begin
      for (int unsigned k = 0; k < 4; k++) begin
        mem[m_address + 16'(k)] <= m_data[16*k +: 16];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NL; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
      mTag[i]   = 0;
    end
    for (int i = 0; i < 65536; i++) shadow[i] = refMem[i];
    expHits   = 0;
    expMisses = 0;
  endtask

  task automatic checkResetState(input string nm);
    chk({nm, ".c_ready"},    64'(c_ready),    64'd0);
    chk({nm, ".c_rdata"},    64'(c_rdata),    64'd0);
    chk({nm, ".m_readM"},    64'(m_readM),    64'd0);
    chk({nm, ".m_writeM"},   64'(m_writeM),   64'd0);
    chk({nm, ".m_data"},     m_data,          {64{1'bz}});
    chk({nm, ".hit_count"},  64'(hit_count),  64'd0);
    chk({nm, ".miss_count"}, 64'(miss_count), 64'd0);
  endtask

  // Drives one request and observes it until c_ready (bounded).
  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, output int lat,
                        output logic [15:0] rdata, output int nR, output int nW,
                        output logic [15:0] rA, output logic [15:0] wA,
                        output logic [63:0] wD);
    lat = -1; rdata = 'x; nR = 0; nW = 0; rA = 'x; wA = 'x; wD = 'x;
    @(negedge clk);
    c_read = rd; c_write = wr; c_address = addr; c_wdata = wd;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (c_ready) begin
        lat   = e;
        rdata = c_rdata;
        break;
      end
      if (m_readM) begin
        if (nR == 0) rA = m_address;
        nR++;
      end
      if (m_writeM) begin
        if (nW == 0) begin
          wA = m_address;
          wD = m_data;
        end
        nW++;
      end
    end
    c_read = 1'b0; c_write = 1'b0;
    @(posedge clk);
  endtask

  task automatic step(input string nm, input bit rd, input bit wr,
                      input logic [15:0] addr, input logic [15:0] wd);
    int idx, tg, vBase, expLat, lat, nR, nW;
    bit hit, wb;
    logic [63:0] expWb, wD;
    logic [15:0] rdata, rA, wA, lBase;
    idx   = (int'(addr) / 4) % NL;
    tg    = int'(addr) / (4 * NL);
    lBase = addr & 16'hFFFC;
    hit   = mValid[idx] && (mTag[idx] == tg);
    wb    = !hit && mValid[idx] && mDirty[idx];
    vBase = (mTag[idx] * NL + idx) * 4;
    expWb = {shadow[vBase + 3], shadow[vBase + 2], shadow[vBase + 1], shadow[vBase]};
    expLat = hit ? 1 : (wb ? 11 : 7);
    if (hit) begin
      expHits++;
    end else begin
      expMisses++;
      if (wb) for (int k = 0; k < 4; k++) refMem[vBase + k] = shadow[vBase + k];
      mTag[idx]   = tg;
      mValid[idx] = 1'b1;
      mDirty[idx] = 1'b0;
    end
    if (wr) begin
      shadow[addr] = wd;
      mDirty[idx]  = 1'b1;
    end
    access(rd, wr, addr, wd, lat, rdata, nR, nW, rA, wA, wD);
    chk({nm, ".latency"}, 64'(lat), 64'(expLat));
    if (!wr) chk({nm, ".rdata"}, 64'(rdata), 64'(shadow[addr]));
    chk({nm, ".fillCycles"},  64'(nR), hit ? 64'd0 : 64'd5);
    chk({nm, ".storeCycles"}, 64'(nW), wb ? 64'd4 : 64'd0);
    if (!hit) chk({nm, ".fillAddr"}, 64'(rA), 64'(lBase));
    if (wb) begin
      chk({nm, ".wbAddr"}, 64'(wA), 64'(vBase));
      chk({nm, ".wbData"}, wD, expWb);
    end
    chk({nm, ".hit_count"},  64'(hit_count),  64'(expHits));
    chk({nm, ".miss_count"}, 64'(miss_count), 64'(expMisses));
  endtask

  initial begin
    int op;
    logic [15:0] a, d;
    reset = 1'b1; c_read = 1'b0; c_write = 1'b0; c_address = '0; c_wdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h9023; mem[1] = 16'h0001; mem[2] = 16'hFFFF; mem[3] = 16'h0000;
    for (int i = 0; i < 65536; i++) refMem[i] = mem[i];
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    reset = 1'b0;

    // Directed scenarios
    step("t1_read2",     1'b1, 1'b0, 16'h0002, 16'h0000);
    step("t2_read0",     1'b1, 1'b0, 16'h0000, 16'h0000);
    step("t3_write1",    1'b0, 1'b1, 16'h0001, 16'hABCD);
    step("t3_dirtyMiss", 1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("t3_memWord1", 64'(mem[1]), 64'h0000_0000_0000_ABCD);
    step("t3_reread1",   1'b1, 1'b0, 16'h0001, 16'h0000);
    step("t4_read4",     1'b1, 1'b0, 16'h0004, 16'h0000);
    step("t4_read14",    1'b1, 1'b0, 16'h0014, 16'h0000);
    step("t5_both",      1'b1, 1'b1, 16'h0000, 16'h1234);
    step("t5_readback",  1'b1, 1'b0, 16'h0000, 16'h0000);

    // Randomized traffic over a few conflicting tags
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 3));
      a  = 16'($urandom_range(0, 63));
      d  = 16'($urandom);
      step("rand", (op != 2), (op >= 2), a, d);
    end

    // Reset while idle, then reset in the middle of a fill
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("reset2");
    @(negedge clk);
    reset = 1'b0;
    modelReset();

    @(negedge clk);
    c_read = 1'b1; c_address = 16'h0020;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_inFill", 64'(m_readM), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("t6_midFill");
    @(negedge clk);
    reset = 1'b0; c_read = 1'b0;
    modelReset();
    step("t6_read0", 1'b1, 1'b0, 16'h0000, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
